// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus for the boot loader.
interface program_loader_if #(
  parameter int ADDR_W = 5
);
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              im_we_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [31:0]       im_wdata_o;

  // slave: the loader (consumes bytes, drives memory writes); master: the host side
  modport slave  (input  byte_valid_i, byte_data_i,
                  output byte_ready_o, im_we_o, im_addr_o, im_wdata_o);
  modport master (output byte_valid_i, byte_data_i,
                  input  byte_ready_o, im_we_o, im_addr_o, im_wdata_o);
endinterface

// File: rtl/program_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them to instruction memory
// from address 0, and holds the CPU in reset until an all-zero terminator word lands.
module program_loader #(
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  program_loader_if.slave   bus,
  output logic [ADDR_W:0]   word_count_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_rst_n_o
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic [ADDR_W:0]   word_count;
  logic              last_addr;

  assign last_addr = (addr == ADDR_W'(MEM_DEPTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr       <= '0;
      byte_idx   <= '0;
      word       <= '0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state      <= RECV;
            addr       <= '0;
            byte_idx   <= '0;
            word_count <= '0;
          end
        end
        RECV: begin
          // ready is 1 throughout RECV, so valid alone qualifies the handshake
          if (bus.byte_valid_i) begin
            word     <= {word[23:0], bus.byte_data_i};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          // terminator takes priority over the full-memory check
          if (word == 32'd0)  state <= DONE;
          else if (last_addr) state <= ERR;
          else begin
            state <= RECV;
            addr  <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // every output is a register or a pure decode of state
  assign bus.byte_ready_o = (state == RECV);
  assign bus.im_we_o      = (state == WRITE);
  assign bus.im_addr_o    = addr;
  assign bus.im_wdata_o   = word;
  assign word_count_o     = word_count;
  assign done_o           = (state == DONE);
  assign err_o            = (state == ERR);
  assign cpu_rst_n_o      = (state == DONE);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboard of expected memory writes checked at each write strobe.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] wc;
  logic       done, err, cpu_rst_n;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(5)) bus ();

  program_loader #(.MEM_DEPTH(32), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bus(bus),
    .word_count_o(wc), .done_o(done), .err_o(err), .cpu_rst_n_o(cpu_rst_n)
  );

  typedef struct packed { logic [4:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int pend     = 0;   // 1: expect DONE next cycle, 2: expect ERR next cycle
  bit acc      = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/check at negedge, return 1 time unit after the next posedge.
  task automatic cyc();
    wr_t e;
    @(negedge clk);
    acc = bus.byte_valid_i && bus.byte_ready_o;
    if (pend == 1) begin
      chk("done_after_term", {31'd0, done}, 32'd1);
      chk("cpu_rst_n_after_term", {31'd0, cpu_rst_n}, 32'd1);
      chk("err_after_term", {31'd0, err}, 32'd0);
    end else if (pend == 2) begin
      chk("err_after_full", {31'd0, err}, 32'd1);
      chk("cpu_rst_n_in_err", {31'd0, cpu_rst_n}, 32'd0);
      chk("done_in_err", {31'd0, done}, 32'd0);
    end
    pend = 0;
    if (bus.im_we_o) begin
      chk("ready_in_write", {31'd0, bus.byte_ready_o}, 32'd0);
      chk("write_expected", sb.size(), (sb.size() == 0) ? 32'd1 : sb.size());
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("im_addr", {27'd0, bus.im_addr_o}, {27'd0, e.addr});
        chk("im_wdata", bus.im_wdata_o, e.data);
        pend = (e.data == 32'd0) ? 1 : (e.addr == 5'd31) ? 2 : 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ready", {31'd0, bus.byte_ready_o}, 32'd1);
    chk("start_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("start_wc", {26'd0, wc}, 32'd0);
    chk("start_err_clr", {31'd0, err}, 32'd0);
    chk("start_done_clr", {31'd0, done}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) cyc();
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) cyc();
    bus.byte_valid_i = 1'b0;
    chk("byte_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [4:0] a, input bit gaps);
    sb.push_back('{addr: a, data: w});
    for (int k = 0; k < 4; k++)
      send_byte(w[31-8*k -: 8], (gaps && k[0]) ? 2 : 0);
    chk("we_latency", {31'd0, bus.im_we_o}, 32'd1);
  endtask

  task automatic load_prog(input logic [31:0] w[$], input bit gaps);
    for (int i = 0; i < w.size(); i++) send_word(w[i], i[4:0], gaps);
    cyc();
    cyc();
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  logic [31:0] prog1[$];
  logic [31:0] prog_q[$];

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    prog1 = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h00000000};

    // reset state
    #3;
    chk("rst_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("rst_we", {31'd0, bus.im_we_o}, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_wc", {26'd0, wc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    chk("idle_ready", {31'd0, bus.byte_ready_o}, 32'd0);

    // 1: back-to-back program
    pulse_start();
    load_prog(prog1, 1'b0);
    chk("t1_wc", {26'd0, wc}, 32'd4);

    // 2: gapped valid, bytes presented during WRITE
    pulse_start();
    load_prog(prog1, 1'b1);
    chk("t2_wc", {26'd0, wc}, 32'd4);

    // 3: overflow without terminator
    prog_q = {};
    for (int i = 0; i < 32; i++) prog_q.push_back(32'hFFFFFFFF);
    pulse_start();
    load_prog(prog_q, 1'b0);
    cyc();
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("t3_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("t3_wc", {26'd0, wc}, 32'd32);

    // 4: terminator at the last address
    prog_q = {};
    for (int i = 0; i < 31; i++) prog_q.push_back(32'h00000001);
    prog_q.push_back(32'h00000000);
    pulse_start();
    load_prog(prog_q, 1'b0);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_err", {31'd0, err}, 32'd0);
    chk("t4_wc", {26'd0, wc}, 32'd32);

    // 5: async reset mid-word, then a clean reload
    pulse_start();
    send_word(32'h20010005, 5'd0, 1'b0);
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("t5_we", {31'd0, bus.im_we_o}, 32'd0);
    chk("t5_addr_data", {27'd0, bus.im_addr_o} | bus.im_wdata_o, 32'd0);
    chk("t5_wc", {26'd0, wc}, 32'd0);
    chk("t5_status", {29'd0, done, err, cpu_rst_n}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t5_sb_empty", sb.size(), 32'd0);
    pulse_start();
    load_prog(prog1, 1'b0);
    chk("t5_wc_final", {26'd0, wc}, 32'd4);

    // 6: restart from DONE
    prog_q = '{32'h3C010001, 32'h00000000};
    pulse_start();
    load_prog(prog_q, 1'b0);
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_wc", {26'd0, wc}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
